// File: rtl/sm83_irq_ctrl.sv
// Interrupt controller for the sm83 core: IF/IE bus registers, source edge latch, irq/wake drive.
// Latency: register reads return one cycle after rd; irq/wake follow IF/IE state combinationally.
// Backpressure: none; the bus strobes are always accepted and source edges are never dropped.
module sm83_irq_ctrl #(
    parameter int          NUM_SRC = 5,
    parameter logic [15:0] ADR_IF  = 16'hFF0F,
    parameter logic [15:0] ADR_IE  = 16'hFFFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [15:0]        adr,
    input  logic [7:0]         din,
    output logic [7:0]         dout,
    output logic               dout_oe,
    input  logic               rd,
    input  logic               wr,
    input  logic [NUM_SRC-1:0] src,
    input  logic [7:0]         iack,
    output logic [7:0]         irq,
    output logic               wake
);

    // Architectural and bus-side state
    logic [NUM_SRC-1:0] r_if;
    logic [7:0]         r_ie;
    logic [NUM_SRC-1:0] r_src_prev;
    logic               r_wr_prev;
    logic [7:0]         r_dout;
    logic               r_dout_oe;

    // Decoded per-cycle events
    logic [NUM_SRC-1:0] w_edge;
    logic               w_wr_commit;
    logic               w_wr_if;
    logic               w_wr_ie;
    logic               w_rd_if;
    logic               w_rd_ie;
    logic [NUM_SRC-1:0] w_if_next;
    logic [7:0]         w_if_rd;
    logic [7:0]         w_irq;
    logic               w_iack_unused;

    // Only the low NUM_SRC acknowledge lines map onto stored IF bits
    assign w_iack_unused = ^iack;

    // Rising edges on request lines; a held-high line never re-triggers
    assign w_edge      = src & ~r_src_prev;

    // A write commits once, on the first cycle of the wr strobe
    assign w_wr_commit = wr & ~r_wr_prev;
    assign w_wr_if     = w_wr_commit && (adr == ADR_IF);
    assign w_wr_ie     = w_wr_commit && (adr == ADR_IE);
    assign w_rd_if     = rd && (adr == ADR_IF);
    assign w_rd_ie     = rd && (adr == ADR_IE);

    // Edge set dominates CPU write, which dominates acknowledge clear
    assign w_if_next   = (w_wr_if ? din[NUM_SRC-1:0] : (r_if & ~iack[NUM_SRC-1:0])) | w_edge;

    // IF read view pads absent bits with ones; irq is the enabled subset of IF
    always_comb begin
        w_if_rd                = 8'hFF;
        w_if_rd[NUM_SRC-1:0]   = r_if;
        w_irq                  = 8'h00;
        w_irq[NUM_SRC-1:0]     = r_if & r_ie[NUM_SRC-1:0];
    end

    // All state updates: reset has priority; read data captures pre-update values
    always_ff @(posedge clk) begin
        if (reset) begin
            r_if       <= '0;
            r_ie       <= 8'h00;
            r_src_prev <= src;
            r_wr_prev  <= 1'b0;
            r_dout     <= 8'h00;
            r_dout_oe  <= 1'b0;
        end else begin
            r_if       <= w_if_next;
            r_src_prev <= src;
            r_wr_prev  <= wr;
            if (w_wr_ie) begin
                r_ie <= din;
            end
            if (w_rd_if) begin
                r_dout    <= w_if_rd;
                r_dout_oe <= 1'b1;
            end else if (w_rd_ie) begin
                r_dout    <= r_ie;
                r_dout_oe <= 1'b1;
            end else begin
                r_dout    <= 8'h00;
                r_dout_oe <= 1'b0;
            end
        end
    end

    assign dout    = r_dout;
    assign dout_oe = r_dout_oe;
    assign irq     = w_irq;
    assign wake    = |w_irq;

endmodule
